// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_pkg
// Description : Shared definitions for the bus-computer microsequencer:
//               opcode values, sequencer state encoding, T-state numbering
//               and control-word bit positions. Imported by the sequencer,
//               the datapath and the bench so every party decodes alike.
// Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

    // Opcodes (IR[7:4])
    localparam logic [3:0] c_op_lda = 4'b0000;
    localparam logic [3:0] c_op_add = 4'b0001;
    localparam logic [3:0] c_op_sub = 4'b0010;
    localparam logic [3:0] c_op_sta = 4'b0011;
    localparam logic [3:0] c_op_jmp = 4'b0100;
    localparam logic [3:0] c_op_jz  = 4'b0101;
    localparam logic [3:0] c_op_jc  = 4'b0110;
    localparam logic [3:0] c_op_out = 4'b1110;
    localparam logic [3:0] c_op_hlt = 4'b1111;

    // T-state numbering as seen on the tstate output; 0 means "not executing"
    localparam logic [2:0] c_t_none = 3'd0;
    localparam logic [2:0] c_t1     = 3'd1;
    localparam logic [2:0] c_t2     = 3'd2;
    localparam logic [2:0] c_t3     = 3'd3;
    localparam logic [2:0] c_t4     = 3'd4;
    localparam logic [2:0] c_t5     = 3'd5;

    // Sequencer mode; the T-state itself lives in the ring counter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    // Control-word bit positions
    localparam int c_cw_pc_en   = 0;
    localparam int c_cw_pc_oe   = 1;
    localparam int c_cw_pc_we   = 2;
    localparam int c_cw_mar_we  = 3;
    localparam int c_cw_ram_oe  = 4;
    localparam int c_cw_ram_we  = 5;
    localparam int c_cw_ir_we   = 6;
    localparam int c_cw_ir_oe   = 7;
    localparam int c_cw_a_we    = 8;
    localparam int c_cw_a_oe    = 9;
    localparam int c_cw_b_we    = 10;
    localparam int c_cw_alu_oe  = 11;
    localparam int c_cw_alu_sub = 12;
    localparam int c_cw_flag_we = 13;
    localparam int c_cw_out_we  = 14;
    localparam int c_cw_w       = 15;

    // Final T-state of each instruction. Never below T3, so a meaningless
    // opcode during fetch (T1/T2) can never end the instruction early.
    function automatic logic [2:0] last_tstate(input logic [3:0] opcode);
        logic [2:0] v_last;
        case (opcode)
            c_op_lda, c_op_sta: v_last = c_t4;
            c_op_add, c_op_sub: v_last = c_t5;
            default:            v_last = c_t3;
        endcase
        return v_last;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_tstate_counter.sv
`default_nettype none
// ============================================================================
// Module      : tstate_counter
// Description : Ring counter T1..T(NUM_T). Synchronous clear loads T1,
//               advance steps to the next T-state (wrapping after the last),
//               otherwise the count holds.
// Ports       : CLK      - clock
//               RESET_N  - asynchronous active-low reset (count -> T1)
//               i_clr    - load T1 on next edge (priority over i_adv)
//               i_adv    - step to next T-state on next edge
//               o_tcount - current T-state, 1..NUM_T
// Revision    : 1.0 - initial release
// ============================================================================
module tstate_counter #(
    parameter int NUM_T = 5
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       i_clr,
    input  logic       i_adv,
    output logic [2:0] o_tcount
);

    localparam logic [2:0] c_first = 3'd1;
    localparam logic [2:0] c_last  = 3'(NUM_T);

    logic [2:0] r_count;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= c_first;
        end else if (i_clr) begin
            r_count <= c_first;
        end else if (i_adv) begin
            r_count <= (r_count == c_last) ? c_first : r_count + 3'd1;
        end
    end

    assign o_tcount = r_count;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Microsequencer for the 4-bit-address bus computer. Steps each
//               instruction through T1..T5 and decodes the control word from
//               (state, T-state, opcode, flags). Owns every bus output-enable.
// Ports       : CLK, RESET_N          - clock, async active-low reset
//               start, run            - leave IDLE / continue past boundary
//               ir_opcode             - IR[7:4], meaningful from T3
//               zero_flag, carry_flag - registered ALU flags, used in T3
//               pc_*, mar_we, ram_*, ir_*, a_*, b_we, alu_*, flag_we, out_we
//                                     - datapath control word
//               halted                - high in HALT
//               tstate                - 1..5 while executing, else 0
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPC_W = 4,
    parameter int NUM_T = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             zero_flag,
    input  logic             carry_flag,
    output logic             pc_en,
    output logic             pc_oe,
    output logic             pc_we,
    output logic             mar_we,
    output logic             ram_oe,
    output logic             ram_we,
    output logic             ir_we,
    output logic             ir_oe,
    output logic             a_we,
    output logic             a_oe,
    output logic             b_we,
    output logic             alu_oe,
    output logic             alu_sub,
    output logic             flag_we,
    output logic             out_we,
    output logic             halted,
    output logic [2:0]       tstate
);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [2:0]          w_tcount;
    logic                w_cnt_clr;
    logic                w_cnt_adv;
    logic                w_exec;
    logic                w_last;
    logic [c_cw_w-1:0]   w_cw;

    tstate_counter #(
        .NUM_T    (NUM_T)
    ) u_tstate_counter (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .i_clr    (w_cnt_clr),
        .i_adv    (w_cnt_adv),
        .o_tcount (w_tcount)
    );

    assign w_exec = (r_state == ST_EXEC);
    assign w_last = w_exec && (w_tcount == last_tstate(ir_opcode));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and counter control. Every entry into execution restarts
    // the ring at T1; while paused the counter simply holds.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_cnt_adv   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (run) begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (w_last) begin
                    if (ir_opcode == c_op_hlt) begin
                        w_state_nxt = ST_HALT;
                    end else if (run) begin
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end else begin
                    w_cnt_adv = 1'b1;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control-word decode. Only one bus driver is ever selected per T-state.
    always_comb begin
        w_cw = '0;
        if (w_exec) begin
            case (w_tcount)
                c_t1: begin
                    w_cw[c_cw_pc_oe]  = 1'b1;
                    w_cw[c_cw_mar_we] = 1'b1;
                end
                c_t2: begin
                    w_cw[c_cw_ram_oe] = 1'b1;
                    w_cw[c_cw_ir_we]  = 1'b1;
                    w_cw[c_cw_pc_en]  = 1'b1;
                end
                c_t3: begin
                    case (ir_opcode)
                        c_op_lda, c_op_add, c_op_sub, c_op_sta: begin
                            w_cw[c_cw_ir_oe]  = 1'b1;
                            w_cw[c_cw_mar_we] = 1'b1;
                        end
                        c_op_jmp: begin
                            w_cw[c_cw_ir_oe] = 1'b1;
                            w_cw[c_cw_pc_we] = 1'b1;
                            w_cw[c_cw_pc_en] = 1'b1;
                        end
                        c_op_jz, c_op_jc: begin
                            if ((ir_opcode == c_op_jz) ? zero_flag : carry_flag) begin
                                w_cw[c_cw_ir_oe] = 1'b1;
                                w_cw[c_cw_pc_we] = 1'b1;
                                w_cw[c_cw_pc_en] = 1'b1;
                            end
                        end
                        c_op_out: begin
                            w_cw[c_cw_a_oe]   = 1'b1;
                            w_cw[c_cw_out_we] = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                c_t4: begin
                    case (ir_opcode)
                        c_op_lda: begin
                            w_cw[c_cw_ram_oe] = 1'b1;
                            w_cw[c_cw_a_we]   = 1'b1;
                        end
                        c_op_add, c_op_sub: begin
                            w_cw[c_cw_ram_oe] = 1'b1;
                            w_cw[c_cw_b_we]   = 1'b1;
                        end
                        c_op_sta: begin
                            w_cw[c_cw_a_oe]   = 1'b1;
                            w_cw[c_cw_ram_we] = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                c_t5: begin
                    if (ir_opcode == c_op_add || ir_opcode == c_op_sub) begin
                        w_cw[c_cw_alu_oe]  = 1'b1;
                        w_cw[c_cw_a_we]    = 1'b1;
                        w_cw[c_cw_flag_we] = 1'b1;
                        w_cw[c_cw_alu_sub] = (ir_opcode == c_op_sub);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_en   = w_cw[c_cw_pc_en];
    assign pc_oe   = w_cw[c_cw_pc_oe];
    assign pc_we   = w_cw[c_cw_pc_we];
    assign mar_we  = w_cw[c_cw_mar_we];
    assign ram_oe  = w_cw[c_cw_ram_oe];
    assign ram_we  = w_cw[c_cw_ram_we];
    assign ir_we   = w_cw[c_cw_ir_we];
    assign ir_oe   = w_cw[c_cw_ir_oe];
    assign a_we    = w_cw[c_cw_a_we];
    assign a_oe    = w_cw[c_cw_a_oe];
    assign b_we    = w_cw[c_cw_b_we];
    assign alu_oe  = w_cw[c_cw_alu_oe];
    assign alu_sub = w_cw[c_cw_alu_sub];
    assign flag_we = w_cw[c_cw_flag_we];
    assign out_we  = w_cw[c_cw_out_we];

    assign halted  = (r_state == ST_HALT);
    assign tstate  = w_exec ? w_tcount : c_t_none;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Scoreboard bench for control_sequencer. The driver computes
//               each cycle's expected outputs from an instruction-level
//               reference model and queues them; a monitor on the falling
//               edge pops and compares, and checks the bus-driver invariant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_PAUSE = 1;
    localparam int M_RUN   = 2;
    localparam int M_HALT  = 3;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       start, run, zero_flag, carry_flag;
    logic [3:0] ir_opcode;
    logic       pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe;
    logic       a_we, a_oe, b_we, alu_oe, alu_sub, flag_we, out_we, halted;
    logic [2:0] tstate;

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    int m_mode = M_IDLE;
    int m_t    = 1;

    logic [18:0] exp_q[$];

    always #5 CLK = ~CLK;

    control_sequencer dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .start      (start),
        .run        (run),
        .ir_opcode  (ir_opcode),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .pc_en      (pc_en),
        .pc_oe      (pc_oe),
        .pc_we      (pc_we),
        .mar_we     (mar_we),
        .ram_oe     (ram_oe),
        .ram_we     (ram_we),
        .ir_we      (ir_we),
        .ir_oe      (ir_oe),
        .a_we       (a_we),
        .a_oe       (a_oe),
        .b_we       (b_we),
        .alu_oe     (alu_oe),
        .alu_sub    (alu_sub),
        .flag_we    (flag_we),
        .out_we     (out_we),
        .halted     (halted),
        .tstate     (tstate)
    );

    // Instruction length in T-states
    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h0, 4'h3: return 4;
            4'h1, 4'h2: return 5;
            default:    return 3;
        endcase
    endfunction

    // Expected control word, order:
    // pc_en pc_oe pc_we mar_we ram_oe ram_we ir_we ir_oe a_we a_oe b_we alu_oe alu_sub flag_we out_we
    function automatic logic [14:0] ref_ctrl(input int t, input logic [3:0] op,
                                             input logic z, input logic c);
        logic e_pc_en = 0, e_pc_oe = 0, e_pc_we = 0, e_mar_we = 0, e_ram_oe = 0;
        logic e_ram_we = 0, e_ir_we = 0, e_ir_oe = 0, e_a_we = 0, e_a_oe = 0;
        logic e_b_we = 0, e_alu_oe = 0, e_alu_sub = 0, e_flag_we = 0, e_out_we = 0;
        logic take;
        if (t == 1) begin
            e_pc_oe = 1; e_mar_we = 1;
        end else if (t == 2) begin
            e_ram_oe = 1; e_ir_we = 1; e_pc_en = 1;
        end else begin
            take = (op == 4'h4) || (op == 4'h5 && z) || (op == 4'h6 && c);
            if (t == 3 && op <= 4'h3) begin e_ir_oe = 1; e_mar_we = 1; end
            if (t == 3 && take)       begin e_ir_oe = 1; e_pc_we = 1; e_pc_en = 1; end
            if (t == 3 && op == 4'hE) begin e_a_oe = 1; e_out_we = 1; end
            if (t == 4 && op == 4'h0) begin e_ram_oe = 1; e_a_we = 1; end
            if (t == 4 && (op == 4'h1 || op == 4'h2)) begin e_ram_oe = 1; e_b_we = 1; end
            if (t == 4 && op == 4'h3) begin e_a_oe = 1; e_ram_we = 1; end
            if (t == 5) begin
                e_alu_oe = 1; e_a_we = 1; e_flag_we = 1; e_alu_sub = (op == 4'h2);
            end
        end
        return {e_pc_en, e_pc_oe, e_pc_we, e_mar_we, e_ram_oe, e_ram_we, e_ir_we, e_ir_oe,
                e_a_we, e_a_oe, e_b_we, e_alu_oe, e_alu_sub, e_flag_we, e_out_we};
    endfunction

    // One clock cycle: apply inputs, queue expected outputs, advance model.
    task automatic cyc(input logic s, input logic r, input logic [3:0] op,
                       input logic z, input logic c);
        logic [14:0] e_cw;
        logic        e_halt;
        logic [2:0]  e_t;
        start = s; run = r; ir_opcode = op; zero_flag = z; carry_flag = c;
        e_cw   = (RESET_N && m_mode == M_RUN) ? ref_ctrl(m_t, op, z, c) : 15'd0;
        e_halt = RESET_N && (m_mode == M_HALT);
        e_t    = (RESET_N && m_mode == M_RUN) ? 3'(m_t) : 3'd0;
        exp_q.push_back({e_cw, e_halt, e_t});
        if (!RESET_N) begin
            m_mode = M_IDLE; m_t = 1;
        end else begin
            case (m_mode)
                M_IDLE:  if (s) begin m_mode = M_RUN; m_t = 1; end
                M_PAUSE: if (r) begin m_mode = M_RUN; m_t = 1; end
                M_RUN: begin
                    if (m_t >= 3 && m_t == instr_len(op)) begin
                        if (op == 4'hF) m_mode = M_HALT;
                        else if (r)     m_t = 1;
                        else            m_mode = M_PAUSE;
                    end else begin
                        m_t = m_t + 1;
                    end
                end
                default: ;
            endcase
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input logic c, input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, op, z, c);
    endtask

    // Monitor: bus invariant every cycle, scoreboard compare when queued.
    always @(negedge CLK) begin
        logic [18:0] e, a;
        cyc_no++;
        checks++;
        bus_onehot: assert ($onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}))
        else begin
            failures++;
            $display("FAIL bus_oe cyc=%0d act=%b req=onehot0", cyc_no,
                     {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe, a_we, a_oe,
                 b_we, alu_oe, alu_sub, flag_we, out_we, halted, tstate};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL ctrl cyc=%0d act cw=%b h=%b t=%0d req cw=%b h=%b t=%0d",
                         cyc_no, a[18:4], a[3], a[2:0], e[18:4], e[3], e[2:0]);
            end
        end
    end

    initial begin
        logic [3:0] cur_op;
        logic [3:0] op;
        RESET_N = 1'b1; start = 0; run = 0; ir_opcode = 0; zero_flag = 0; carry_flag = 0;
        #2 RESET_N = 1'b0;
        @(posedge CLK); #1;
        cyc(0, 0, 4'h0, 0, 0);
        cyc(1, 1, 4'h0, 0, 0);          // start ignored while in reset
        RESET_N = 1'b1;

        // Leave IDLE, then LDA, SUB, JZ taken, JZ not taken
        cyc(1, 1, 4'h0, 0, 0);
        run_instr(4'h0, 0, 0, 4);
        run_instr(4'h2, 0, 0, 5);
        run_instr(4'h5, 1, 0, 3);
        run_instr(4'h5, 0, 1, 3);
        run_instr(4'h6, 0, 1, 3);

        // OUT with run dropped in T2: finishes T3 then pauses
        cyc(1, 1, 4'hE, 0, 0);
        cyc(1, 0, 4'hE, 0, 0);
        cyc(1, 0, 4'hE, 0, 0);
        cyc(1, 0, 4'hE, 0, 0);
        cyc(1, 0, 4'h3, 0, 0);
        cyc(0, 1, 4'h3, 0, 0);
        run_instr(4'h3, 0, 0, 4);

        // ADD interrupted by asynchronous reset in T4
        run_instr(4'h1, 0, 0, 3);
        RESET_N = 1'b0;
        cyc(1, 1, 4'h1, 0, 0);
        cyc(1, 1, 4'h1, 0, 0);
        RESET_N = 1'b1;

        // Randomized instruction stream (no HLT)
        cur_op = 4'h0;
        for (int i = 0; i < 600; i++) begin
            if (m_mode == M_RUN && m_t >= 3) begin
                op = cur_op;
            end else begin
                cur_op = 4'($urandom_range(0, 14));
                op     = 4'($urandom);
            end
            cyc(1'($urandom), ($urandom_range(0, 3) != 0), op, 1'($urandom), 1'($urandom));
        end

        // HLT: terminal until reset, start/run ignored
        RESET_N = 1'b0;
        cyc(0, 0, 4'hF, 0, 0);
        RESET_N = 1'b1;
        cyc(1, 1, 4'hF, 0, 0);
        run_instr(4'hF, 0, 0, 3);
        for (int i = 0; i < 20; i++)
            cyc(1, 1, 4'($urandom), 1'($urandom), 1'($urandom));

        // Reset releases HALT
        RESET_N = 1'b0;
        cyc(1, 1, 4'h0, 0, 0);
        RESET_N = 1'b1;
        cyc(0, 1, 4'h0, 0, 0);

        @(negedge CLK); #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain act=%0d req=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
